// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: decodes the ALU operation from alu_op/funct and issues it
// through a valid/ready output stage. Multiply and divide may hold the slot
// for MUL_LAT/DIV_LAT cycles (state EXEC) before the result is presented.
//
// Optional feature: define ALUCTL_ILLEGAL_EN to drive 'illegal' for unknown
// funct codes under alu_op=11. Without it, 'illegal' is tied low.
//
// Handshake: an input transfer happens on a rising edge with in_valid&in_ready.
// An output transfer happens on a rising edge with out_valid&out_ready. The
// out_valid, operation and illegal outputs come straight from flops, so
// in_valid has no combinational path to out_valid. in_ready depends on
// out_ready combinationally, so a finished result and a new request can
// change hands on the same edge.
module alu_issue_ctrl #(
  parameter int FUNCT_W = 4,
  parameter int OPER_W  = 4,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         alu_op,
  input  logic [FUNCT_W-1:0] funct,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OPER_W-1:0]  operation,
  output logic               busy,
  output logic               illegal,
  output logic [1:0]         state_dbg
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [OPER_W-1:0]   operation_q, operation_d;
  logic                illegal_q, illegal_d;

  logic [3:0]          dec_op;
  logic                dec_ill;
  logic                dec_mul;
  logic                dec_div;
  logic                funct_hi_zero;
  logic                accept;

  // Any set bit above funct[3:0] makes the code unknown.
  assign funct_hi_zero = ((funct >> 4) == '0);

  // Decode the requested class/function into the 4-bit operation code.
  always_comb begin
    dec_op  = 4'b0001;
    dec_ill = 1'b0;
    dec_mul = 1'b0;
    dec_div = 1'b0;
    case (alu_op)
      2'b00: dec_op = 4'b0000;
      2'b01: dec_op = 4'b1001;
      2'b10: dec_op = 4'b0111;
      default: begin
        if (!funct_hi_zero) begin
          dec_ill = 1'b1;
        end else begin
          case (funct[3:0])
            4'b0000: dec_op = 4'b0001;
            4'b0010: dec_op = 4'b0010;
            4'b0100: begin dec_op = 4'b0011; dec_mul = 1'b1; end
            4'b0101: begin dec_op = 4'b0100; dec_div = 1'b1; end
            4'b0111: dec_op = 4'b0101;
            4'b1000: dec_op = 4'b0110;
            default: dec_ill = 1'b1;
          endcase
        end
      end
    endcase
  end

  assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  // Next-state, latency counter and result-register update.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    operation_d = operation_q;
    illegal_d   = illegal_q;
    if (accept) begin
      operation_d = OPER_W'(dec_op);
      illegal_d   = dec_ill;
      if (dec_mul && (MUL_LAT > 1)) begin
        state_d = EXEC;
        cnt_d   = CNT_W'(MUL_LAT - 1);
      end else if (dec_div && (DIV_LAT > 1)) begin
        state_d = EXEC;
        cnt_d   = CNT_W'(DIV_LAT - 1);
      end else begin
        state_d = DONE;
        cnt_d   = '0;
      end
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        EXEC: begin
          if (cnt_q == CNT_W'(1)) begin
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State and result registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      operation_q <= '0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      operation_q <= operation_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == EXEC);
  assign operation = operation_q;
  assign state_dbg = state_q;

`ifdef ALUCTL_ILLEGAL_EN
  assign illegal = illegal_q;
`else
  // Unknown codes still issue 0001; the flag itself is not reported.
  logic ill_unused;
  assign ill_unused = illegal_q;
  assign illegal    = 1'b0;
`endif

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have parameter FUNCT_W, default 4, meaning function-field width (min 4; bits above [3:0] SHALL be 0 for a legal code).
REQ-002 SHALL have parameter OPER_W, default 4, meaning operation-code width (min 4; codes zero-extended).
REQ-003 SHALL have parameter MUL_LAT, default 4, meaning issue-to-result cycles for mult (min 1).
REQ-004 SHALL have parameter DIV_LAT, default 8, meaning issue-to-result cycles for division (min 1).
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port in_valid  input  1  request present.
REQ-008 SHALL have port in_ready  output  1  request accepted this cycle when in_valid=1.
REQ-009 SHALL have port alu_op  input  2  class from main control.
REQ-010 SHALL have port funct  input  FUNCT_W  R-type function field.
REQ-011 SHALL have port out_valid  output  1  operation valid.
REQ-012 SHALL have port out_ready  input  1  consumer takes operation.
REQ-013 SHALL have port operation  output  OPER_W  registered ALU operation code.
REQ-014 SHALL have port busy  output  1  multi-cycle op in progress.
REQ-015 SHALL have port illegal  output  1  qualifies operation as from unknown funct (see Configuration).

Function
REQ-016 Decode SHALL be: alu_op 00->0000 (jump/halt), 01->1001 (branch), 10->0111 (OR/AND), 11->funct table.
REQ-017 funct table SHALL be: 0000->0001 add, 0010->0010 sub, 0100->0011 mult, 0101->0100 div, 0111->0101 move, 1000->0110 swap, any other->0001.
REQ-018 Handshake: transfer on in_valid&in_ready; out transfer on out_valid&out_ready; no combinational path in_valid->out_valid.
REQ-019 FSM states SHALL be IDLE, EXEC, DONE.
REQ-020 in_ready SHALL be 1 in IDLE, 1 in DONE when out_ready=1, 0 otherwise.
REQ-021 Single-cycle op (all except mult/div, or LAT=1) accepted at edge N -> DONE, out_valid=1 after edge N.
REQ-022 Mult/div with LAT>1 -> EXEC, counter loaded LAT-1, decremented each cycle; counter 1->0 transition enters DONE, so out_valid rises exactly LAT cycles after accept.
REQ-023 busy SHALL equal (state==EXEC).
REQ-024 In DONE with out_ready=0: operation, illegal, out_valid SHALL hold stable.
REQ-025 In DONE with out_ready=1 and new accept same cycle: next state per REQ-021/022 for the new op (back-to-back, one op per cycle for single-cycle ops); without new accept -> IDLE, out_valid=0.
REQ-026 in_valid/alu_op/funct SHALL be ignored in EXEC.

Reset
REQ-027 rst_n=0 SHALL immediately force state IDLE, counter 0, out_valid 0, operation 0, busy 0, illegal 0.
REQ-028 Reset during EXEC or DONE SHALL discard the op; no out_valid after release until a new accept.
REQ-029 First accept SHALL be possible on the first rising edge with rst_n=1.

Configuration
REQ-030 Macro ALUCTL_ILLEGAL_EN SHALL select illegal-funct reporting.
REQ-031 Defined: unknown funct under alu_op 11 (incl. nonzero upper FUNCT_W bits) issues 0001 with illegal=1 held with out_valid; legal ops illegal=0.
REQ-032 Undefined: illegal tied 0; unknown funct silently issues 0001.

Verification
REQ-033 alu_op=11, funct=0010, out_ready=1 -> out_valid next cycle, operation=0010, busy never 1.
REQ-034 alu_op=11, funct=0101, DIV_LAT=8 -> busy 7 cycles, out_valid exactly 8 cycles after accept, operation=0100, in_ready=0 throughout.
REQ-035 out_ready=0 three cycles after alu_op=10 -> operation=0111 stable, in_ready=0; out_ready=1 with in_valid (alu_op=01) -> next cycle operation=1001.
REQ-036 funct=0011 under alu_op=11 -> operation=0001; illegal=1 with ALUCTL_ILLEGAL_EN, 0 without.
REQ-037 rst_n low mid-mult (cycle 2 of 4) -> out_valid, busy, operation 0 asynchronously; no result after release.
